// File: rtl/bram_snapshot_ctrl.sv
// Trigger-driven snapshot capture: arm, wait for trig, skip DELAY valid samples,
// then stream LENGTH valid samples into the fabric write port of a dual-port BRAM.
module bram_snapshot_ctrl #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int DELAY_WIDTH    = 16
) (
  input  logic                      fabric_clk,
  input  logic                      fabric_rst_n,
  input  logic                      arm,
  input  logic                      trig,
  input  logic [DELAY_WIDTH-1:0]    delay,
  input  logic [RAM_ADDR_WIDTH:0]   length,
  input  logic                      din_valid,
  input  logic [RAM_DATA_WIDTH-1:0] din,
  output logic                      fabric_we,
  output logic [RAM_ADDR_WIDTH-1:0] fabric_addr,
  output logic [RAM_DATA_WIDTH-1:0] fabric_data_in,
  output logic                      busy,
  output logic                      done,
  output logic [RAM_ADDR_WIDTH:0]   count
);

  localparam int LW = RAM_ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [DELAY_WIDTH-1:0]    dly_cfg, dly_rem;
  logic [LW-1:0]             len_cfg, len_norm;
  logic [RAM_ADDR_WIDTH-1:0] ptr;
  logic                      arm_ok, trig_hit, wr_fire, last_wr;
  logic                      busy_nxt, done_nxt;

  // Out-of-range lengths (0 or beyond the RAM) fall back to a full-depth capture.
  assign len_norm = (length == '0 || length > DEPTH) ? DEPTH : length;
  assign last_wr  = (count + LW'(1)) == len_cfg;

  always_ff @(posedge fabric_clk) begin
    if (!fabric_rst_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm_ok    = 1'b0;
    trig_hit  = 1'b0;
    wr_fire   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          arm_ok    = 1'b1;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (arm) begin
          arm_ok = 1'b1;
        end else if (trig) begin
          trig_hit = 1'b1;
          if (dly_cfg == '0) begin
            wr_fire   = din_valid;
            state_nxt = (din_valid && last_wr) ? S_DONE : S_CAPTURE;
          end else if (din_valid && dly_cfg == DELAY_WIDTH'(1)) begin
            state_nxt = S_CAPTURE;
          end else begin
            state_nxt = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (din_valid && dly_rem == DELAY_WIDTH'(1)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (din_valid) begin
          wr_fire = 1'b1;
          if (last_wr) state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_DELAY) || (state_nxt == S_CAPTURE);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge fabric_clk) begin
    if (!fabric_rst_n) begin
      fabric_we      <= 1'b0;
      fabric_addr    <= '0;
      fabric_data_in <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      count          <= '0;
      ptr            <= '0;
      dly_cfg        <= '0;
      dly_rem        <= '0;
      len_cfg        <= '0;
    end else begin
      fabric_we <= wr_fire;
      busy      <= busy_nxt;
      done      <= done_nxt;
      if (wr_fire) begin
        fabric_addr    <= ptr;
        fabric_data_in <= din;
        ptr            <= ptr + RAM_ADDR_WIDTH'(1);
        count          <= count + LW'(1);
      end
      if (arm_ok) begin
        dly_cfg <= delay;
        len_cfg <= len_norm;
        ptr     <= '0;
        count   <= '0;
      end
      // The trigger-cycle valid sample already counts as the first skipped one.
      if (trig_hit)
        dly_rem <= dly_cfg - DELAY_WIDTH'(din_valid);
      else if (state == S_DELAY && din_valid)
        dly_rem <= dly_rem - DELAY_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_bram_snapshot_ctrl.sv
// Bench for bram_snapshot_ctrl: directed scenarios plus randomized captures,
// BRAM writes checked by a scoreboard fed from a sample-index reference model.
module tb_bram_snapshot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, trig, din_valid;
  logic [15:0] delay;
  logic [8:0]  length;
  logic [31:0] din;
  logic        fabric_we, busy, done;
  logic [7:0]  fabric_addr;
  logic [31:0] fabric_data_in;
  logic [8:0]  count;

  always #5 clk = ~clk;

  bram_snapshot_ctrl #(.RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(8), .DELAY_WIDTH(16)) dut (
    .fabric_clk(clk), .fabric_rst_n(rst_n), .arm(arm), .trig(trig), .delay(delay),
    .length(length), .din_valid(din_valid), .din(din), .fabric_we(fabric_we),
    .fabric_addr(fabric_addr), .fabric_data_in(fabric_data_in), .busy(busy),
    .done(done), .count(count)
  );

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: tracks valid samples since trigger, not controller states.
  bit m_armed, m_run, m_done;
  int m_vidx, m_cnt, m_D, m_L;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (fabric_we) begin
      if (q.size() == 0) begin
        chk("unexpected_write_addr", {56'd0, fabric_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", {56'd0, fabric_addr}, {56'd0, e.a});
        chk("wr_data", {32'd0, fabric_data_in}, {32'd0, e.d});
      end
    end
  end

  function automatic int norm_len(input int l);
    return (l == 0 || l > 256) ? 256 : l;
  endfunction

  task automatic model_clear();
    m_armed = 0; m_run = 0; m_done = 0; m_vidx = 0; m_cnt = 0; m_D = 0; m_L = 0;
  endtask

  task automatic cyc(input logic a, input logic t, input logic v, input logic [31:0] d);
    arm = a; trig = t; din_valid = v; din = d;
    if (a && !m_run) begin
      m_armed = 1; m_done = 0; m_cnt = 0;
      m_D = int'(delay); m_L = norm_len(int'(length));
    end else if (m_armed && t) begin
      m_armed = 0; m_run = 1; m_vidx = 0;
    end
    if (m_run && v) begin
      if (m_vidx >= m_D) begin
        wr_t e;
        e.a = 8'(m_cnt); e.d = d;
        q.push_back(e);
        m_cnt++;
        if (m_cnt == m_L) begin
          m_run = 0; m_done = 1;
        end
      end
      m_vidx++;
    end
    @(posedge clk); #1;
    chk("busy", {63'd0, busy}, {63'd0, (m_armed || m_run)});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("count", {55'd0, count}, 64'(m_cnt));
    arm = 0; trig = 0; din_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; arm = 0; trig = 0; din_valid = 0; din = '0;
    @(posedge clk); #1;
    chk("rst_we", {63'd0, fabric_we}, 64'd0);
    chk("rst_addr", {56'd0, fabric_addr}, 64'd0);
    chk("rst_data", {32'd0, fabric_data_in}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_count", {55'd0, count}, 64'd0);
    chk("rst_queue_empty", 64'(q.size()), 64'd0);
    q.delete();
    model_clear();
    rst_n = 1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[7];
    lens = '{1, 2, 3, 7, 0, 256, 300};
    rst_n = 0; arm = 0; trig = 0; din_valid = 0; din = '0; delay = '0; length = '0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // 1: delay 0, length 4, continuous valid
    delay = 0; length = 4;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 32'hA0);
    for (int i = 1; i < 4; i++) cyc(0, 0, 1, 32'hA0 + 32'(i));
    cyc(0, 0, 1, 32'hEE);

    // 2: delay 3, length 2
    delay = 3; length = 2;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 32'd10);
    for (int i = 11; i < 15; i++) cyc(0, 0, 1, 32'(i));
    cyc(0, 0, 0, 0);

    // 3: length 0 -> full depth, then extra valid samples must not write
    delay = 0; length = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 32'h1000);
    for (int i = 1; i < 260; i++) cyc(0, 0, 1, 32'h1000 + 32'(i));

    // 4: gapped valid during capture, arm mid-capture ignored
    delay = 1; length = 4;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 32'h40);
    cyc(0, 0, 1, 32'h41);
    cyc(1, 0, 0, 32'h42);
    cyc(0, 0, 0, 32'h43);
    cyc(0, 0, 1, 32'h44);
    cyc(1, 1, 1, 32'h45);
    cyc(0, 0, 1, 32'h46);
    cyc(0, 0, 1, 32'h47);

    // 5: reset after 2 of 8 samples, then full re-capture
    delay = 0; length = 8;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 32'h50);
    cyc(0, 0, 1, 32'h51);
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 32'h60);
    for (int i = 1; i < 8; i++) cyc(0, 0, 1, 32'h60 + 32'(i));

    // 6: arm+trig together only arms; re-arm from DONE clears done/count
    delay = 0; length = 2;
    cyc(1, 1, 1, 32'h70);
    cyc(0, 0, 1, 32'h71);
    cyc(0, 1, 1, 32'h72);
    cyc(0, 0, 1, 32'h73);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'h74);

    // Randomized captures
    for (int n = 0; n < 30; n++) begin
      int budget;
      delay  = 16'($urandom_range(0, 5));
      length = 9'(lens[$urandom_range(0, 6)]);
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        cyc(1'($urandom_range(0, 7) == 0), 0, 1'($urandom_range(0, 1)), $urandom);
      cyc(0, 1, 1'($urandom_range(0, 1)), $urandom);
      budget = 3000;
      while (m_run && budget > 0) begin
        cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) < 7), $urandom);
        budget--;
      end
      if (budget == 0) chk("capture_timeout", 64'd1, 64'd0);
      cyc(0, 1, 1, $urandom);
    end

    @(posedge clk); #1;
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
